ifetch: RTL and testbench

IFETCH -- requirements
Module: ifetch

---
 rtl/ifetch.sv | 51 +++++
 tb/tb_ifetch.sv | 92 +++++++++
 2 files changed

// File: rtl/ifetch.sv
// ifetch: PC register plus IF/ID register with jump flush and hold stall.
// Define IFETCH_PERF_CNT_EN to build the delivered-instruction counter.
module ifetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    input  logic [31:0] inst_i,
    output logic [31:0] inst_addr_o,
    output logic [31:0] id_inst_o,
    output logic [31:0] id_inst_addr_o,
    output logic        id_valid_o,
    output logic [31:0] fetch_cnt_o
);
    logic [31:0] pc;
    assign inst_addr_o = pc;
    always_ff @(posedge clk) begin
        if (rst) pc <= RESET_PC;
        else if (jump_en_i) pc <= {jump_addr_i[31:2], 2'b00};
        else if (!hold_i) pc <= pc + 32'd4;
    end
    // a flush keeps the old id address; only the word and valid change
    always_ff @(posedge clk) begin
        if (rst) begin
            id_inst_o      <= NOP_INST;
            id_inst_addr_o <= RESET_PC;
            id_valid_o     <= 1'b0;
        end else if (jump_en_i) begin
            id_inst_o  <= NOP_INST;
            id_valid_o <= 1'b0;
        end else if (!hold_i) begin
            id_inst_o      <= inst_i;
            id_inst_addr_o <= pc;
            id_valid_o     <= 1'b1;
        end
    end
`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (!jump_en_i && !hold_i) cnt <= cnt + 32'd1;
    end
    assign fetch_cnt_o = cnt;
`else
    assign fetch_cnt_o = '0;
`endif
endmodule

// File: tb/tb_ifetch.sv
// tb_ifetch: directed checks of ifetch with a ROM that returns the address as data.
module tb_ifetch;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IFETCH_PERF_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_en_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_i = 1'b0;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_o, id_inst_o, id_inst_addr_o, fetch_cnt_o;
    logic        id_valid_o;
    int checks = 0;
    int errors = 0;

    ifetch dut (
        .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
        .hold_i(hold_i), .inst_i(inst_i), .inst_addr_o(inst_addr_o),
        .id_inst_o(id_inst_o), .id_inst_addr_o(id_inst_addr_o),
        .id_valid_o(id_valid_o), .fetch_cnt_o(fetch_cnt_o)
    );

    assign inst_i = inst_addr_o;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                        input logic [31:0] addr, input logic valid, input int cnt);
        chk({tag, ".pc"}, inst_addr_o, pc);
        chk({tag, ".inst"}, id_inst_o, inst);
        chk({tag, ".addr"}, id_inst_addr_o, addr);
        chk({tag, ".valid"}, {31'b0, id_valid_o}, {31'b0, valid});
        chk({tag, ".cnt"}, fetch_cnt_o, CNT_EN ? cnt : 0);
    endtask

    initial begin
        step();
        rst = 1'b0;
        look("reset", 32'h0, NOP, 32'h0, 1'b0, 0);
        step(); look("run1", 32'h4, 32'h0, 32'h0, 1'b1, 1);
        step(); look("run2", 32'h8, 32'h4, 32'h4, 1'b1, 2);
        hold_i = 1'b1;
        step(); look("hold1", 32'h8, 32'h4, 32'h4, 1'b1, 2);
        step(); look("hold2", 32'h8, 32'h4, 32'h4, 1'b1, 2);
        step(); look("hold3", 32'h8, 32'h4, 32'h4, 1'b1, 2);
        hold_i = 1'b0;
        step(); look("release1", 32'hC, 32'h8, 32'h8, 1'b1, 3);
        step(); look("release2", 32'h10, 32'hC, 32'hC, 1'b1, 4);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0103;
        step(); look("jump", 32'h100, NOP, 32'hC, 1'b0, 4);
        jump_en_i = 1'b0;
        step(); look("target", 32'h104, 32'h100, 32'h100, 1'b1, 5);
        jump_en_i = 1'b1; jump_addr_i = 32'h0000_0200; hold_i = 1'b1;
        step(); look("jumphold", 32'h200, NOP, 32'h100, 1'b0, 5);
        jump_en_i = 1'b0;
        step(); look("bubblehold", 32'h200, NOP, 32'h100, 1'b0, 5);
        hold_i = 1'b0;
        step(); look("jh_target", 32'h204, 32'h200, 32'h200, 1'b1, 6);
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFF8;
        step(); look("wrapjump", 32'hFFFF_FFF8, NOP, 32'h200, 1'b0, 6);
        jump_en_i = 1'b0;
        step(); look("wrap1", 32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'hFFFF_FFF8, 1'b1, 7);
        step(); look("wrap2", 32'h0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1, 8);
        step(); look("wrap3", 32'h4, 32'h0, 32'h0, 1'b1, 9);
        hold_i = 1'b1;
        step(); look("prerst_hold", 32'h4, 32'h0, 32'h0, 1'b1, 9);
        rst = 1'b1;
        step(); look("rst_hold", 32'h0, NOP, 32'h0, 1'b0, 0);
        rst = 1'b0;
        step(); look("post_rst_hold", 32'h0, NOP, 32'h0, 1'b0, 0);
        hold_i = 1'b0;
        step(); look("restart", 32'h4, 32'h0, 32'h0, 1'b1, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
